ps2_rx_frame: RTL and testbench

- PS/2 keyboard receive front end. Sits directly upstream of the keyboard input of the bk0010 core, between the raw PS2_CLK/PS2_DAT board pins and the core's scancode consumer.
- Synchronises and deglitches the PS/2 lines, then deframes 11-bit device-to-host frames and checks parity and stop bit.
- Buffers good bytes in a small FIFO and presents them through a valid/ack handshake in the clk25 domain.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_rx_fifo.sv | 63 ++++++
 rtl/ps2_rx_frame.sv | 239 +++++++++++++++++++++++
 tb/tb_ps2_rx_frame.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive front end: FSM encoding, prefix
// bytes, frame length and FIFO entry width.
// Build option: PS2_PREFIX_DECODE_EN widens FIFO entries to carry E0/F0 flags.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT       = 8'hE0;
  localparam logic [7:0] PS2_BRK       = 8'hF0;
  localparam int         PS2_FRAME_LEN = 11;

`ifdef PS2_PREFIX_DECODE_EN
  // Entry layout: {extended, released, byte}
  localparam int PS2_ENTRY_W = 10;
`else
  localparam int PS2_ENTRY_W = 8;
`endif

endpackage

// File: rtl/ps2_rx_fifo.sv
// Small synchronous FIFO with full/empty flags. A push and a pop in the
// same cycle both take effect, even when full. Pop on empty is ignored;
// push on full without a pop is dropped (caller flags the overflow).
module ps2_rx_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int DEPTH = 2 ** AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign dout_o  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_push  = push_i && (!full_o || pop_i);
    do_pop   = pop_i && !empty_o;
    if (do_push) begin
      mem_d[wr_ptr_q] = din_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // Register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host receiver: synchronise + deglitch the clock, deframe
// 11-bit frames, check parity/stop, queue good bytes for the consumer.
// Build option: PS2_PREFIX_DECODE_EN folds E0/F0 prefixes into entry flags.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 25000,
  parameter int FIFO_AW    = 2
) (
  input  logic       clk25,
  input  logic       reset_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ack_i,
  output logic       extended_o,
  output logic       released_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       overflow_o
);

  localparam int FW        = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW        = $clog2(TIMEOUT + 1);
  localparam int DATA_BITS = PS2_FRAME_LEN - 3;

  logic                   clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic                   filt_clk_q, filt_clk_d;
  logic [FW-1:0]          filt_cnt_q, filt_cnt_d;
  logic                   strobe_q, strobe_d;

  ps2_state_e             state_q, state_d;
  logic [2:0]             bitcnt_q, bitcnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic [TW-1:0]          to_cnt_q, to_cnt_d;
  logic                   push_q, push_d;
  logic [PS2_ENTRY_W-1:0] push_data_q, push_data_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   ovf_q, ovf_d;
`ifdef PS2_PREFIX_DECODE_EN
  logic                   ext_pend_q, ext_pend_d;
  logic                   brk_pend_q, brk_pend_d;
`endif

  logic [PS2_ENTRY_W-1:0] head;
  logic                   fifo_empty, fifo_full;

  // Deglitch: filtered clock follows only after FILTER_LEN differing samples.
  always_comb begin
    filt_clk_d = filt_clk_q;
    filt_cnt_d = filt_cnt_q;
    if (clk_s2_q == filt_clk_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
      filt_clk_d = clk_s2_q;
      filt_cnt_d = '0;
    end else begin
      filt_cnt_d = filt_cnt_q + FW'(1);
    end
    strobe_d = filt_clk_q & ~filt_clk_d;
  end

  // Synchroniser, filter and bit-strobe registers.
  always_ff @(posedge clk25) begin
    if (!reset_n) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_clk_q <= 1'b1;
      filt_cnt_q <= '0;
      strobe_q   <= 1'b0;
    end else begin
      clk_s1_q   <= ps2_clk_i;
      clk_s2_q   <= clk_s1_q;
      dat_s1_q   <= ps2_dat_i;
      dat_s2_q   <= dat_s1_q;
      filt_clk_q <= filt_clk_d;
      filt_cnt_q <= filt_cnt_d;
      strobe_q   <= strobe_d;
    end
  end

  // Frame FSM: next state, shift register, checks, timeout and push request.
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    perr_d      = 1'b0;
    ferr_d      = 1'b0;
`ifdef PS2_PREFIX_DECODE_EN
    ext_pend_d  = ext_pend_q;
    brk_pend_d  = brk_pend_q;
`endif
    to_cnt_d    = (state_q == ST_IDLE || strobe_q) ? '0 : to_cnt_q + TW'(1);
    ovf_d       = ovf_q | (push_q & fifo_full & ~ack_i);

    case (state_q)
      ST_IDLE: begin
        if (strobe_q && !dat_s2_q) begin
          state_d  = ST_DATA;
          bitcnt_d = '0;
        end
      end
      ST_DATA: begin
        if (strobe_q) begin
          shift_d  = {dat_s2_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'(DATA_BITS - 1)) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (strobe_q) begin
          par_d   = dat_s2_q;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (strobe_q) begin
          state_d = ST_IDLE;
          if (!dat_s2_q) begin
            ferr_d = 1'b1;
`ifdef PS2_PREFIX_DECODE_EN
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
`endif
          end else if (!(^{shift_q, par_q})) begin
            perr_d = 1'b1;
`ifdef PS2_PREFIX_DECODE_EN
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
`endif
          end else begin
`ifdef PS2_PREFIX_DECODE_EN
            if (shift_q == PS2_EXT) begin
              ext_pend_d = 1'b1;
            end else if (shift_q == PS2_BRK) begin
              brk_pend_d = 1'b1;
            end else begin
              push_d      = 1'b1;
              push_data_d = {ext_pend_q, brk_pend_q, shift_q};
              ext_pend_d  = 1'b0;
              brk_pend_d  = 1'b0;
            end
`else
            push_d      = 1'b1;
            push_data_d = shift_q;
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A stalled partial frame is abandoned after TIMEOUT idle cycles.
    if (state_q != ST_IDLE && !strobe_q && to_cnt_q == TW'(TIMEOUT)) begin
      state_d  = ST_IDLE;
      ferr_d   = 1'b1;
      bitcnt_d = '0;
      shift_d  = '0;
      par_d    = 1'b0;
      to_cnt_d = '0;
`ifdef PS2_PREFIX_DECODE_EN
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
`endif
    end
  end

  // Frame FSM and status registers.
  always_ff @(posedge clk25) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef PS2_PREFIX_DECODE_EN
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovf_q       <= ovf_d;
`ifdef PS2_PREFIX_DECODE_EN
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
`endif
    end
  end

  ps2_rx_fifo #(
    .W  (PS2_ENTRY_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk25),
    .reset_n (reset_n),
    .push_i  (push_q),
    .din_i   (push_data_q),
    .pop_i   (ack_i),
    .dout_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign valid_o      = ~fifo_empty;
  assign data_o       = head[7:0];
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign overflow_o   = ovf_q;
`ifdef PS2_PREFIX_DECODE_EN
  assign extended_o   = head[9];
  assign released_o   = head[8];
`else
  assign extended_o   = 1'b0;
  assign released_o   = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Bench for ps2_rx_frame: bit-level PS/2 device driver, reference model with
// expected-entry queue, error-pulse monitor and final report.
// Honours PS2_PREFIX_DECODE_EN the same way the design does.
module tb_ps2_rx_frame;

  localparam int HALF = 40;  // clk25 cycles per PS/2 clock half period

  logic       clk25 = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk_i = 1'b1;
  logic       ps2_dat_i = 1'b1;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ack_i = 1'b0;
  logic       extended_o, released_o;
  logic       parity_err_o, frame_err_o, overflow_o;

  int total = 0;
  int bad   = 0;

  // Scoreboard state: entries are {extended, released, byte}
  logic [9:0] exp_q[$];
  logic       exp_ovf = 1'b0;
  logic       pend_ext = 1'b0;
  logic       pend_brk = 1'b0;
  int         perr_cnt = 0;
  int         ferr_cnt = 0;

  ps2_rx_frame dut (
    .clk25        (clk25),
    .reset_n      (reset_n),
    .ps2_clk_i    (ps2_clk_i),
    .ps2_dat_i    (ps2_dat_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ack_i        (ack_i),
    .extended_o   (extended_o),
    .released_o   (released_o),
    .parity_err_o (parity_err_o),
    .frame_err_o  (frame_err_o),
    .overflow_o   (overflow_o)
  );

  // Clock generation
  always #20 clk25 = ~clk25;

  // Count error pulse cycles; a stuck pulse shows as a count above one
  always @(negedge clk25) begin
    if (parity_err_o === 1'b1) perr_cnt++;
    if (frame_err_o === 1'b1) ferr_cnt++;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk25);
  endtask

  task automatic model_push(input logic [9:0] e);
    if (exp_q.size() < 4) exp_q.push_back(e);
    else exp_ovf = 1'b1;
  endtask

  task automatic model_good(input logic [7:0] b);
`ifdef PS2_PREFIX_DECODE_EN
    if (b == 8'hE0) pend_ext = 1'b1;
    else if (b == 8'hF0) pend_brk = 1'b1;
    else begin
      model_push({pend_ext, pend_brk, b});
      pend_ext = 1'b0;
      pend_brk = 1'b0;
    end
`else
    model_push({2'b00, b});
`endif
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk25);
    ps2_dat_i = b;
    cycles(HALF);
    ps2_clk_i = 1'b0;
    cycles(HALF);
    ps2_clk_i = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit stop_bit);
    logic par;
    par = ~(^b) ^ flip_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(stop_bit);
    ps2_dat_i = 1'b1;
    if (!stop_bit || flip_par) begin
      pend_ext = 1'b0;
      pend_brk = 1'b0;
    end else begin
      model_good(b);
    end
    cycles(HALF);
  endtask

  // Pop n expected entries, acking each one
  task automatic drain(input int n, input string name);
    int w;
    logic [9:0] exp;
    for (int k = 0; k < n; k++) begin
      w = 0;
      while (valid_o !== 1'b1 && w < 100) begin
        cycles(1);
        w++;
      end
      total++;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
      if (valid_o !== 1'b1) begin
        bad++;
        $display("FAIL %s_valid entry %0d: valid_o=%b expected 1", name, k, valid_o);
      end else if ({extended_o, released_o, data_o} !== exp) begin
        bad++;
        $display("FAIL %s_entry %0d: got ext=%b rel=%b data=%h expected ext=%b rel=%b data=%h",
                 name, k, extended_o, released_o, data_o, exp[9], exp[8], exp[7:0]);
      end
      ack_i = 1'b1;
      cycles(1);
      ack_i = 1'b0;
    end
    cycles(2);
    total++;
    if (valid_o !== (exp_q.size() > 0)) begin
      bad++;
      $display("FAIL %s_after_drain: valid_o=%b expected %b", name, valid_o, exp_q.size() > 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk25);
    reset_n = 1'b0;
    cycles(3);
    reset_n = 1'b1;
    exp_q.delete();
    exp_ovf  = 1'b0;
    pend_ext = 1'b0;
    pend_brk = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cycles(2);
    total++;
    if ({valid_o, data_o, extended_o, released_o, parity_err_o, frame_err_o, overflow_o} !== 14'h0) begin
      bad++;
      $display("FAIL reset_outputs: valid=%b data=%h ext=%b rel=%b perr=%b ferr=%b ovf=%b expected all 0",
               valid_o, data_o, extended_o, released_o, parity_err_o, frame_err_o, overflow_o);
    end
  endtask

  task automatic test_single_frame();
    logic [7:0] b;
    int lat;
    b = 8'h1C;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b));
    total++;
    if (valid_o !== 1'b0) begin
      bad++;
      $display("FAIL single_early_valid: valid_o=%b expected 0", valid_o);
    end
    // Stop bit done by hand to measure latency from its falling edge
    @(negedge clk25);
    ps2_dat_i = 1'b1;
    cycles(HALF);
    ps2_clk_i = 1'b0;
    lat = 0;
    while (valid_o !== 1'b1 && lat < 40) begin
      cycles(1);
      lat++;
    end
    total++;
    if (lat < 4 || lat > 30) begin
      bad++;
      $display("FAIL single_latency: valid after %0d cycles expected 4..30", lat);
    end
    cycles(HALF);
    ps2_clk_i = 1'b1;
    model_good(b);
    cycles(HALF);
    drain(1, "single");
  endtask

  task automatic test_parity_err();
    int p0, f0;
    p0 = perr_cnt;
    f0 = ferr_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
    cycles(20);
    total++;
    if (perr_cnt - p0 !== 1) begin
      bad++;
      $display("FAIL parity_pulse: %0d cycles expected 1", perr_cnt - p0);
    end
    total++;
    if (ferr_cnt - f0 !== 0 || valid_o !== 1'b0) begin
      bad++;
      $display("FAIL parity_side: ferr=%0d valid=%b expected 0 0", ferr_cnt - f0, valid_o);
    end
  endtask

  task automatic test_stop_err();
    int p0, f0;
    p0 = perr_cnt;
    f0 = ferr_cnt;
    send_frame(8'h4B, 1'b1, 1'b0);
    cycles(20);
    total++;
    if (ferr_cnt - f0 !== 1 || perr_cnt - p0 !== 0) begin
      bad++;
      $display("FAIL stop_err: ferr=%0d perr=%0d expected 1 0", ferr_cnt - f0, perr_cnt - p0);
    end
    total++;
    if (valid_o !== 1'b0) begin
      bad++;
      $display("FAIL stop_err_valid: valid_o=%b expected 0", valid_o);
    end
  endtask

  task automatic test_glitch();
    int p0, f0;
    p0 = perr_cnt;
    f0 = ferr_cnt;
    @(negedge clk25);
    ps2_dat_i = 1'b0;
    cycles(3);
    ps2_clk_i = 1'b0;
    cycles(5);
    ps2_clk_i = 1'b1;
    cycles(30);
    ps2_dat_i = 1'b1;
    cycles(HALF);
    total++;
    if (perr_cnt !== p0 || ferr_cnt !== f0 || valid_o !== 1'b0) begin
      bad++;
      $display("FAIL glitch_quiet: perr=%0d ferr=%0d valid=%b expected 0 0 0",
               perr_cnt - p0, ferr_cnt - f0, valid_o);
    end
    send_frame(8'h5A, 1'b0, 1'b1);
    drain(1, "glitch");
    total++;
    if (perr_cnt !== p0 || ferr_cnt !== f0) begin
      bad++;
      $display("FAIL glitch_frame_errs: perr=%0d ferr=%0d expected 0 0", perr_cnt - p0, ferr_cnt - f0);
    end
  endtask

  task automatic test_prefix();
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    drain(exp_q.size(), "prefix");
  endtask

  task automatic test_timeout();
    int f0, w;
    logic [7:0] b;
    b = 8'hA5;
    f0 = ferr_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    cycles(24800);
    total++;
    if (ferr_cnt !== f0) begin
      bad++;
      $display("FAIL timeout_early: %0d pulses before 25000 cycles expected 0", ferr_cnt - f0);
    end
    w = 0;
    while (ferr_cnt == f0 && w < 400) begin
      cycles(1);
      w++;
    end
    cycles(5);
    total++;
    if (ferr_cnt - f0 !== 1) begin
      bad++;
      $display("FAIL timeout_pulse: %0d pulse cycles expected 1", ferr_cnt - f0);
    end
    pend_ext = 1'b0;
    pend_brk = 1'b0;
    send_frame(8'h29, 1'b0, 1'b1);
    drain(1, "timeout");
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1);
    cycles(5);
    total++;
    if (overflow_o !== exp_ovf) begin
      bad++;
      $display("FAIL overflow_flag: overflow_o=%b expected %b", overflow_o, exp_ovf);
    end
    drain(4, "overflow");
    total++;
    if (overflow_o !== 1'b1) begin
      bad++;
      $display("FAIL overflow_sticky: overflow_o=%b expected 1", overflow_o);
    end
  endtask

  task automatic test_reset_mid();
    send_frame(8'h16, 1'b0, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    do_reset();
    cycles(1);
    total++;
    if ({valid_o, overflow_o, parity_err_o, frame_err_o} !== 4'b0) begin
      bad++;
      $display("FAIL reset_mid_outputs: valid=%b ovf=%b perr=%b ferr=%b expected 0",
               valid_o, overflow_o, parity_err_o, frame_err_o);
    end
    send_frame(8'h33, 1'b0, 1'b1);
    drain(1, "reset_mid");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity_err();
    test_stop_err();
    test_glitch();
    test_prefix();
    test_timeout();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
